// File: rtl/pc_fetch_unit.sv
// PC fetch unit: three-state FETCH/HOLD/TRAP sequencer for a single-issue core.
// Define MISALIGN_TRAP_EN to trap on misaligned redirect targets.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PCTarget,
    input  logic        PCSrc,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        misalign_err
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        TRAP  = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        req_q;
    logic        valid_q;
    logic [31:0] pc_inc;
    logic [31:0] redirect_pc;
    logic [31:0] next_pc;
    logic        misaligned;

    assign pc_inc = pc_q + 32'd4;

`ifdef MISALIGN_TRAP_EN
    logic err_q;

    assign misaligned   = PCSrc && (PCTarget[1:0] != 2'b00);
    assign redirect_pc  = PCTarget;
    assign misalign_err = err_q;
`else
    logic unused_tgt_lsb;

    // Low target bits are dropped, so a bad target can never trap.
    assign unused_tgt_lsb = ^PCTarget[1:0];
    assign misaligned     = 1'b0;
    assign redirect_pc    = {PCTarget[31:2], 2'b00};
    assign misalign_err   = 1'b0;
`endif

    assign next_pc = PCSrc ? redirect_pc : pc_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FETCH;
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
            req_q   <= 1'b1;
            valid_q <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            err_q   <= 1'b0;
`endif
        end else begin
            unique case (state)
                FETCH: begin
                    if (imem_ack) begin
                        instr_q <= imem_rdata;
                        state   <= HOLD;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        pc_q    <= next_pc;
                        valid_q <= 1'b0;
                        if (misaligned) begin
                            state <= TRAP;
                            req_q <= 1'b0;
`ifdef MISALIGN_TRAP_EN
                            err_q <= 1'b1;
`endif
                        end else begin
                            state <= FETCH;
                            req_q <= 1'b1;
                        end
                    end
                end
                TRAP: begin
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
                default: begin
                    // Unused encoding: restart fetching at the held PC.
                    state   <= FETCH;
                    req_q   <= 1'b1;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign PC          = pc_q;
    assign PCPlus4     = pc_inc;
    assign instr       = instr_q;
    assign instr_valid = valid_q;

endmodule
